game_round_ctrl: RTL and testbench

GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

---
 rtl/game_round_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_game_round_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_ctrl.sv
// Two-board guessing-game round controller: synchronizes and debounces the peer
// board's handshake, runs the round FSM and produces the restart pulse to the peer.

module stab_filter #(
  parameter int W          = 1,
  parameter int STABLE_CYC = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] hold;
  logic [3:0]   cnt;

  // Any change restarts the count; the value is accepted once it has held long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= '0;
      cnt  <= '0;
      dout <= '0;
    end else if (din != hold) begin
      hold <= din;
      cnt  <= '0;
    end else if (cnt == 4'(STABLE_CYC - 1)) begin
      dout <= hold;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end
endmodule

module game_round_ctrl #(
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 10_000_000,
  parameter int RST_PULSE   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       peer_link,
  input  logic       peer_rdy,
  input  logic [3:0] peer_person,
  input  logic [1:0] peer_result,
  input  logic       peer_rst,
  input  logic       person_valid,
  input  logic [3:0] person_sel,
  input  logic       guess_valid,
  input  logic [3:0] guess_sel,
  input  logic       restart,
  output logic [5:0] state_bin,
  output logic [3:0] tx_person,
  output logic       tx_rdy,
  output logic [1:0] tx_result,
  output logic       tx_rst,
  output logic [1:0] result,
  output logic       timeout_err
);
  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_CHOOSE = 6'b000010,
    S_WAIT   = 6'b000100,
    S_GUESS  = 6'b001000,
    S_RESULT = 6'b010000,
    S_ERROR  = 6'b100000
  } state_t;

  state_t state, state_d;

  logic [8:0] sync1, sync2;
  logic       s_link;
  logic       rdy_st, prst_st;
  logic [3:0] pp_st, peer_q;
  logic [1:0] pr_st;
  logic [23:0] tcnt;
  logic [7:0]  rst_cnt;
  logic latch_person, take_peer, set_guess, set_peer_res, start_rst;

  function automatic logic code_ok(input logic [3:0] c);
    return (c >= 4'd1) && (c <= 4'd9);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {peer_link, peer_rdy, peer_person, peer_result, peer_rst};
      sync2 <= sync1;
    end
  end

  assign s_link = sync2[8];

  stab_filter #(.W(1), .STABLE_CYC(STABLE_CYC)) u_st_rdy (
    .clk(clk), .rst(rst), .din(sync2[7]),   .dout(rdy_st));
  stab_filter #(.W(4), .STABLE_CYC(STABLE_CYC)) u_st_person (
    .clk(clk), .rst(rst), .din(sync2[6:3]), .dout(pp_st));
  stab_filter #(.W(2), .STABLE_CYC(STABLE_CYC)) u_st_result (
    .clk(clk), .rst(rst), .din(sync2[2:1]), .dout(pr_st));
  stab_filter #(.W(1), .STABLE_CYC(STABLE_CYC)) u_st_rst (
    .clk(clk), .rst(rst), .din(sync2[0]),   .dout(prst_st));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  assign start_rst = restart && ((state == S_RESULT) || (state == S_ERROR));

  always_comb begin
    state_d      = state;
    latch_person = 1'b0;
    take_peer    = 1'b0;
    set_guess    = 1'b0;
    set_peer_res = 1'b0;
    if (!s_link && (state != S_IDLE) && (state != S_ERROR)) begin
      state_d = S_ERROR;
    end else begin
      case (state)
        S_IDLE:   if (s_link) state_d = S_CHOOSE;
        S_CHOOSE: if (person_valid && code_ok(person_sel)) begin
          latch_person = 1'b1;
          state_d      = S_WAIT;
        end
        S_WAIT: begin
          if (rdy_st && code_ok(pp_st)) begin
            take_peer = 1'b1;
            state_d   = S_GUESS;
          end else if (tcnt == 24'(TIMEOUT_CYC - 1)) begin
            state_d = S_ERROR;
          end
        end
        // The local guess wins over a peer result arriving in the same cycle.
        S_GUESS: begin
          if (guess_valid && code_ok(guess_sel)) begin
            set_guess = 1'b1;
            state_d   = S_RESULT;
          end else if ((pr_st == 2'b01) || (pr_st == 2'b10)) begin
            set_peer_res = 1'b1;
            state_d      = S_RESULT;
          end
        end
        S_RESULT, S_ERROR: if (restart || prst_st) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_person   <= '0;
      tx_rdy      <= 1'b0;
      tx_result   <= '0;
      result      <= '0;
      timeout_err <= 1'b0;
      peer_q      <= '0;
      tcnt        <= '0;
      rst_cnt     <= '0;
    end else begin
      tcnt <= (state == S_WAIT) ? tcnt + 24'd1 : '0;

      // The restart pulse runs on its own counter so it survives the return to IDLE.
      if (start_rst)          rst_cnt <= 8'(RST_PULSE);
      else if (rst_cnt != '0) rst_cnt <= rst_cnt - 8'd1;

      if (state_d == S_IDLE && state != S_IDLE) begin
        tx_person   <= '0;
        tx_rdy      <= 1'b0;
        tx_result   <= '0;
        result      <= '0;
        timeout_err <= 1'b0;
        peer_q      <= '0;
      end
      if (latch_person) begin
        tx_person <= person_sel;
        tx_rdy    <= 1'b1;
      end
      if (take_peer) peer_q <= pp_st;
      if (set_guess) begin
        result    <= (guess_sel == peer_q) ? 2'b10 : 2'b01;
        tx_result <= (guess_sel == peer_q) ? 2'b10 : 2'b01;
      end
      // Peer reports its own outcome, so ours is the opposite.
      if (set_peer_res) result <= (pr_st == 2'b01) ? 2'b10 : 2'b01;
      if (state_d == S_ERROR) timeout_err <= 1'b1;
    end
  end

  assign state_bin = state;
  assign tx_rst    = (rst_cnt != '0);

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl: table of full rounds plus hand sequences
// for timeout, restart pulse, link loss and reset abort.

module tb_game_round_ctrl;
  localparam logic [5:0] IDLE = 6'b000001, CHOOSE = 6'b000010, WAITP = 6'b000100,
                         GUESS = 6'b001000, RESULT = 6'b010000, ERROR = 6'b100000;

  logic clk = 1'b0;
  logic rst, peer_link, peer_rdy, peer_rst, person_valid, guess_valid, restart;
  logic [3:0] peer_person, person_sel, guess_sel;
  logic [1:0] peer_result;
  logic [5:0] state_bin;
  logic [3:0] tx_person;
  logic       tx_rdy, tx_rst, timeout_err;
  logic [1:0] tx_result, result;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  game_round_ctrl #(.STABLE_CYC(4), .TIMEOUT_CYC(100), .RST_PULSE(16)) dut (
    .clk(clk), .rst(rst), .peer_link(peer_link), .peer_rdy(peer_rdy),
    .peer_person(peer_person), .peer_result(peer_result), .peer_rst(peer_rst),
    .person_valid(person_valid), .person_sel(person_sel),
    .guess_valid(guess_valid), .guess_sel(guess_sel), .restart(restart),
    .state_bin(state_bin), .tx_person(tx_person), .tx_rdy(tx_rdy),
    .tx_result(tx_result), .tx_rst(tx_rst), .result(result),
    .timeout_err(timeout_err));

  typedef struct {
    logic [3:0] ps;
    logic [3:0] pp;
    logic [1:0] pr;
    logic       g;
    logic [3:0] gs;
    logic [1:0] er;
    logic [1:0] etx;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic wait_state(input string nm, input logic [5:0] exp, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (state_bin == exp) break;
    end
    chk(nm, 32'(state_bin), 32'(exp));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    peer_link = 0; peer_rdy = 0; peer_person = 0; peer_result = 0; peer_rst = 0;
    person_valid = 0; person_sel = 0; guess_valid = 0; guess_sel = 0; restart = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, " tx_person"}, 32'(tx_person), 0);
    chk({nm, " tx_rdy"}, 32'(tx_rdy), 0);
    chk({nm, " tx_result"}, 32'(tx_result), 0);
    chk({nm, " result"}, 32'(result), 0);
    chk({nm, " timeout_err"}, 32'(timeout_err), 0);
  endtask

  task automatic go_guess(input logic [3:0] ps, input logic [3:0] pp, input logic [1:0] pr);
    do_reset();
    peer_person = pp;
    peer_result = pr;
    peer_link   = 1'b1;
    wait_state("to_choose", CHOOSE, 10);
    person_sel = ps;
    person_valid = 1'b1;
    @(negedge clk);
    person_valid = 1'b0;
    chk("to_wait", 32'(state_bin), 32'(WAITP));
    chk("tx_person", 32'(tx_person), 32'(ps));
    chk("tx_rdy", 32'(tx_rdy), 1);
    repeat (10) @(negedge clk);
    chk("wait_holds", 32'(state_bin), 32'(WAITP));
    peer_rdy = 1'b1;
    wait_state("to_guess", GUESS, 20);
  endtask

  task automatic run_round(input vec_t v);
    go_guess(v.ps, v.pp, v.pr);
    if (v.g) begin
      guess_valid = 1'b1;
      guess_sel   = v.gs;
    end
    @(negedge clk);
    guess_valid = 1'b0;
    chk("to_result", 32'(state_bin), 32'(RESULT));
    chk("result", 32'(result), 32'(v.er));
    chk("tx_result", 32'(tx_result), 32'(v.etx));
  endtask

  task automatic restart_check(input string nm);
    int n;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk({nm, " to_idle"}, 32'(state_bin), 32'(IDLE));
    chk_cleared(nm);
    chk({nm, " tx_rst_first"}, 32'(tx_rst), 1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (tx_rst) n++;
      @(negedge clk);
    end
    chk({nm, " tx_rst_len"}, 32'(n), 16);
  endtask

  initial begin
    vt[0] = '{4'd3, 4'd7, 2'b00, 1'b1, 4'd7, 2'b10, 2'b10};
    vt[1] = '{4'd3, 4'd7, 2'b00, 1'b1, 4'd5, 2'b01, 2'b01};
    vt[2] = '{4'd4, 4'd2, 2'b01, 1'b0, 4'd0, 2'b10, 2'b00};
    vt[3] = '{4'd4, 4'd2, 2'b10, 1'b0, 4'd0, 2'b01, 2'b00};
    vt[4] = '{4'd9, 4'd9, 2'b01, 1'b1, 4'd1, 2'b01, 2'b01};
    vt[5] = '{4'd1, 4'd1, 2'b10, 1'b1, 4'd1, 2'b10, 2'b10};

    do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst state", 32'(state_bin), 32'(IDLE));
    chk("rst tx_rst", 32'(tx_rst), 0);
    chk_cleared("rst");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_round(vt[i]);

    // Invalid person codes, then a peer whose person never settles -> timeout.
    begin
      int n;
      do_reset();
      peer_link = 1'b1;
      wait_state("inv to_choose", CHOOSE, 10);
      person_sel = 4'd0; person_valid = 1'b1;
      @(negedge clk);
      person_sel = 4'd12;
      @(negedge clk);
      person_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("inv stay_choose", 32'(state_bin), 32'(CHOOSE));
      chk("inv tx_rdy", 32'(tx_rdy), 0);
      person_sel = 4'd9; person_valid = 1'b1;
      @(negedge clk);
      person_valid = 1'b0;
      chk("sel9 to_wait", 32'(state_bin), 32'(WAITP));
      chk("sel9 tx_person", 32'(tx_person), 9);
      peer_rdy = 1'b1;
      n = 0;
      for (int i = 0; i < 300; i++) begin
        if (state_bin != WAITP) break;
        n++;
        if (i % 2 == 0) peer_person = (peer_person == 4'd7) ? 4'd3 : 4'd7;
        @(negedge clk);
      end
      chk("timeout cycles", 32'(n), 100);
      chk("timeout state", 32'(state_bin), 32'(ERROR));
      chk("timeout_err", 32'(timeout_err), 1);
      restart_check("err_restart");
    end

    run_round(vt[0]);
    restart_check("res_restart");

    run_round(vt[2]);
    peer_rst = 1'b1;
    wait_state("peer_rst to_idle", IDLE, 20);
    chk("peer_rst result", 32'(result), 0);
    chk("peer_rst tx_rst", 32'(tx_rst), 0);
    peer_rst = 1'b0;

    go_guess(4'd2, 4'd5, 2'b00);
    peer_link = 1'b0;
    wait_state("link_drop", ERROR, 6);
    chk("link_drop timeout_err", 32'(timeout_err), 1);

    go_guess(4'd2, 4'd5, 2'b00);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_guess state", 32'(state_bin), 32'(IDLE));
    chk("rst_guess tx_rst", 32'(tx_rst), 0);
    chk_cleared("rst_guess");
    rst = 1'b0;

    begin
      int n;
      run_round(vt[1]);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      repeat (4) @(negedge clk);
      chk("pulse active", 32'(tx_rst), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_pulse tx_rst", 32'(tx_rst), 0);
      chk("rst_pulse state", 32'(state_bin), 32'(IDLE));
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (tx_rst) n++;
      end
      chk("rst_pulse stays_low", 32'(n), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
